// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS-style pipeline: ALU opcodes,
// forward-select codes and the packed control-bit bundle.
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;
    localparam logic [3:0] ALU_DIV = 4'd7;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM result, MEM/WB data or the registered
// operand for one source index. EX/MEM is younger and wins; r0 never forwards.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_val,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    logic [1:0] sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != RW'(REG_ZERO)) && (exmem_rd == idx))
            sel = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != RW'(REG_ZERO)) && (memwb_rd == idx))
            sel = FWD_MEMWB;
    end

    always_comb begin
        data = reg_val;
        case (sel)
            FWD_EXMEM: data = exmem_res;
            FWD_MEMWB: data = memwb_data;
            default:   data = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU through forwarding muxes, with
// load-use bubble insertion, branch flush and downstream hold.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_alusrc,
    input  logic [3:0]    id_alu_sel,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          flush,
    input  logic          hold,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic          id_stall,
    output logic [DW-1:0] ex_ea,
    output logic [DW-1:0] ex_eb,
    output logic [3:0]    ex_sel,
    output logic [DW-1:0] ex_store_data,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic [RW-1:0] ex_rd
);

    logic          valid_q;
    ctrl_t         ctrl_q;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] rs_val_q, rt_val_q, imm_q;
    logic          alusrc_q;
    logic [3:0]    sel_q;

    ctrl_t         id_ctrl;
    logic          lu;
    logic          kill;
    logic [DW-1:0] fwd_rs, fwd_rt;

    assign id_ctrl = ctrl_t'({id_regwrite, id_memread, id_memwrite, id_memtoreg} & {4{id_valid}});

    // rt is compared even for immediate-form instructions: a spurious stall is cheaper than a missed one.
    assign lu = id_valid && valid_q && ctrl_q.memread && (rd_q != RW'(REG_ZERO))
             && ((rd_q == id_rs) || (rd_q == id_rt));

    assign id_stall = lu | hold;

    // Flush beats hold; a load-use bubble only goes in when the stage is free to advance.
    assign kill = flush | (!hold & lu);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // Data registers are cleared too: a bubble must present zero operands to the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            alusrc_q <= 1'b0;
            sel_q    <= ALU_ADD;
        end else if (!hold) begin
            valid_q  <= id_valid;
            ctrl_q   <= id_ctrl;
            rs_q     <= id_rs;
            rt_q     <= id_rt;
            rd_q     <= id_rd;
            rs_val_q <= id_rs_val;
            rt_val_q <= id_rt_val;
            imm_q    <= id_imm;
            alusrc_q <= id_alusrc;
            sel_q    <= id_alu_sel;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx            (rs_q),
        .reg_val        (rs_val_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx            (rt_q),
        .reg_val        (rt_val_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rt)
    );

    assign ex_ea         = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_eb         = alusrc_q ? imm_q : fwd_rt;
    assign ex_sel        = sel_q;
    assign ex_valid      = valid_q;
    assign ex_regwrite   = ctrl_q.regwrite;
    assign ex_memread    = ctrl_q.memread;
    assign ex_memwrite   = ctrl_q.memwrite;
    assign ex_memtoreg   = ctrl_q.memtoreg;
    assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, load-use
// bubble, hold/flush interaction and reset during a load-use stall.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [DW-1:0] id_rs_val, id_rt_val, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_alusrc;
    logic [3:0]    id_alu_sel;
    logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          flush, hold;
    logic          exmem_regwrite;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_res;
    logic          memwb_regwrite;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_data;
    logic          id_stall;
    logic [DW-1:0] ex_ea, ex_eb, ex_store_data;
    logic [3:0]    ex_sel;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [RW-1:0] ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alusrc(id_alusrc), .id_alu_sel(id_alu_sel),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .flush(flush), .hold(hold),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .id_stall(id_stall), .ex_ea(ex_ea), .ex_eb(ex_eb), .ex_sel(ex_sel),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_alusrc = 0; id_alu_sel = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        flush = 0; hold = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_res = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        id_valid = 1; id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_memtoreg = 1;
        id_alu_sel = 4'd6; id_rd = 5'd7; id_rs_val = 32'h1234;
        tick();
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        checks++; if (ex_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", ex_sel); end
        checks++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl got %b exp 0000", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", ex_rd); end
        checks++; if (ex_ea !== 32'h0) begin errors++; $display("FAIL reset_ea got %h exp 0", ex_ea); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", id_stall); end
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_plain_load();
        idle_inputs();
        id_valid = 1; id_rs_val = 32'd5; id_rt_val = 32'd7; id_alusrc = 0;
        id_alu_sel = 4'd1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_regwrite = 1;
        tick();
        checks++; if (ex_ea !== 32'd5) begin errors++; $display("FAIL load_ea got %h exp 5", ex_ea); end
        checks++; if (ex_eb !== 32'd7) begin errors++; $display("FAIL load_eb got %h exp 7", ex_eb); end
        checks++; if (ex_sel !== 4'd1) begin errors++; $display("FAIL load_sel got %0d exp 1", ex_sel); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL load_rd got %0d exp 3", ex_rd); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %0b exp 1", ex_valid); end
        checks++; if (ex_regwrite !== 1'b1) begin errors++; $display("FAIL load_regwrite got %0b exp 1", ex_regwrite); end
        checks++; if (ex_store_data !== 32'd7) begin errors++; $display("FAIL load_store got %h exp 7", ex_store_data); end
        id_alusrc = 1; id_imm = 32'hFFFF_FFFC;
        tick();
        checks++; if (ex_eb !== 32'hFFFF_FFFC) begin errors++; $display("FAIL imm_eb got %h exp fffffffc", ex_eb); end
        checks++; if (ex_store_data !== 32'd7) begin errors++; $display("FAIL imm_store got %h exp 7", ex_store_data); end
        // invalid slot: control bits are masked even if decode asserts them
        id_valid = 0; id_regwrite = 1; id_memwrite = 1;
        tick();
        checks++; if ({ex_valid, ex_regwrite, ex_memwrite} !== 3'b000)
            begin errors++; $display("FAIL invalid_mask got %b exp 000", {ex_valid, ex_regwrite, ex_memwrite}); end
        idle_inputs();
    endtask

    task automatic test_forward();
        idle_inputs();
        id_valid = 1; id_rs = 5'd4; id_rt = 5'd4; id_rs_val = 32'hA; id_rt_val = 32'hB;
        tick();
        idle_inputs();
        exmem_regwrite = 1; exmem_rd = 5'd4; exmem_res = 32'h11;
        memwb_regwrite = 1; memwb_rd = 5'd4; memwb_data = 32'h22;
        #1;
        checks++; if (ex_ea !== 32'h11) begin errors++; $display("FAIL fwd_exmem_ea got %h exp 11", ex_ea); end
        checks++; if (ex_eb !== 32'h11) begin errors++; $display("FAIL fwd_exmem_eb got %h exp 11", ex_eb); end
        checks++; if (ex_store_data !== 32'h11) begin errors++; $display("FAIL fwd_exmem_store got %h exp 11", ex_store_data); end
        exmem_regwrite = 0;
        #1;
        checks++; if (ex_ea !== 32'h22) begin errors++; $display("FAIL fwd_memwb_ea got %h exp 22", ex_ea); end
        checks++; if (ex_eb !== 32'h22) begin errors++; $display("FAIL fwd_memwb_eb got %h exp 22", ex_eb); end
        exmem_regwrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        checks++; if (ex_ea !== 32'hA) begin errors++; $display("FAIL fwd_none_ea got %h exp a", ex_ea); end
        checks++; if (ex_eb !== 32'hB) begin errors++; $display("FAIL fwd_none_eb got %h exp b", ex_eb); end
        // mismatched index on EX/MEM must not hide a matching MEM/WB
        exmem_rd = 5'd5; memwb_rd = 5'd4;
        #1;
        checks++; if (ex_ea !== 32'h22) begin errors++; $display("FAIL fwd_idx_mismatch got %h exp 22", ex_ea); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1; id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_rd = 5'd8;
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 5'd8; id_rt = 5'd2; id_rs_val = 32'h50; id_rd = 5'd10; id_regwrite = 1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid got %0b exp 0", ex_valid); end
        checks++; if ({ex_regwrite, ex_memread, ex_memtoreg} !== 3'b000)
            begin errors++; $display("FAIL lu_bubble_ctrl got %b exp 000", {ex_regwrite, ex_memread, ex_memtoreg}); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_ea !== 32'h50)
            begin errors++; $display("FAIL lu_reload got valid=%0b rd=%0d ea=%h exp 1/10/50", ex_valid, ex_rd, ex_ea); end
        // rt match also stalls
        idle_inputs();
        id_valid = 1; id_memread = 1; id_rd = 5'd6;
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd6;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall got %0b exp 1", id_stall); end
        // load to r0 never stalls
        idle_inputs();
        id_valid = 1; id_memread = 1; id_rd = 5'd0;
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_r0 got %0b exp 0", id_stall); end
        idle_inputs();
    endtask

    task automatic test_flush_hold();
        idle_inputs();
        id_valid = 1; id_rd = 5'd9; id_rs = 5'd6; id_rs_val = 32'h99; id_regwrite = 1;
        tick();
        idle_inputs();
        hold = 1; id_valid = 1; id_rd = 5'd12; id_rs_val = 32'h1; id_memwrite = 1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall got %0b exp 1", id_stall); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_rd !== 5'd9 || ex_valid !== 1'b1 || ex_ea !== 32'h99 || ex_memwrite !== 1'b0)
                begin errors++; $display("FAIL hold_frozen_%0d got rd=%0d valid=%0b ea=%h exp 9/1/99", i, ex_rd, ex_valid, ex_ea); end
        end
        exmem_regwrite = 1; exmem_rd = 5'd6; exmem_res = 32'h77;
        #1;
        checks++; if (ex_ea !== 32'h77) begin errors++; $display("FAIL hold_fwd got %h exp 77", ex_ea); end
        exmem_regwrite = 0;
        flush = 1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_rd !== 5'd0)
            begin errors++; $display("FAIL flush_hold got valid=%0b rw=%0b rd=%0d exp 0/0/0", ex_valid, ex_regwrite, ex_rd); end
        // flush together with load-use
        idle_inputs();
        id_valid = 1; id_memread = 1; id_rd = 5'd8;
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 5'd8; id_regwrite = 1; id_rd = 5'd3; flush = 1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL flush_lu_stall got %0b exp 1", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0)
            begin errors++; $display("FAIL flush_lu_bubble got valid=%0b mr=%0b exp 0/0", ex_valid, ex_memread); end
        idle_inputs();
    endtask

    task automatic test_reset_during_lu();
        idle_inputs();
        id_valid = 1; id_memread = 1; id_rd = 5'd8;
        tick();
        idle_inputs();
        id_valid = 1; id_rs = 5'd8;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL rst_lu_pre got %0b exp 1", id_stall); end
        rst_n = 0;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_rd !== 5'd0)
            begin errors++; $display("FAIL rst_lu_empty got valid=%0b mr=%0b rd=%0d exp 0/0/0", ex_valid, ex_memread, ex_rd); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_lu_stall got %0b exp 0", id_stall); end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_forward();
        test_load_use();
        test_flush_hold();
        test_reset_during_lu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
